// File: rtl/cpu_types_pkg.sv
// Shared datapath types: ALU/MDU opcodes, MDU sequencer states and the
// poison value returned by unsupported operations.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL   = 4'd0,
    ALU_SRL   = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_SUB   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MULT  = 4'd10,
    ALU_MULTU = 4'd11,
    ALU_DIV   = 4'd12,
    ALU_DIVU  = 4'd13
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam logic [31:0] ALU_BAD_RESULT = 32'h0BADC0DE;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide core: 2*WORD_W accumulator, step counter and one
// shift-add (multiply) or restoring-subtract (divide, only with ALU_MDU_DIV_EN) step per cycle.
module mdu_iter #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_start,
  input  logic              i_run,
  input  logic              i_is_div,
  input  logic [WORD_W-1:0] i_opa,
  input  logic [WORD_W-1:0] i_opb,
  output logic              o_last,
  output logic [WORD_W-1:0] o_hi,
  output logic [WORD_W-1:0] o_lo
);

  localparam int CW = $clog2(WORD_W);

  logic [2*WORD_W-1:0] r_acc;
  logic [2*WORD_W-1:0] w_acc_next;
  logic [WORD_W-1:0]   r_opb;
  logic [CW-1:0]       r_cnt;
  logic [WORD_W:0]     w_sum;

`ifdef ALU_MDU_DIV_EN
  logic            r_is_div;
  logic [WORD_W:0] w_rem_sh;
  logic [WORD_W:0] w_diff;
`else
  logic w_unused_div;
  assign w_unused_div = i_is_div;
`endif

  always_comb begin
    // Multiply: add multiplicand into the high half when the LSB is set, then shift right.
    w_sum      = {1'b0, r_acc[2*WORD_W-1:WORD_W]} + {1'b0, (r_acc[0] ? r_opb : '0)};
    w_acc_next = {w_sum, r_acc[WORD_W-1:1]};
`ifdef ALU_MDU_DIV_EN
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    w_rem_sh = {r_acc[2*WORD_W-1:WORD_W], r_acc[WORD_W-1]};
    w_diff   = w_rem_sh - {1'b0, r_opb};
    if (r_is_div) begin
      if (!w_diff[WORD_W]) w_acc_next = {w_diff[WORD_W-1:0], r_acc[WORD_W-2:0], 1'b1};
      else                 w_acc_next = {w_rem_sh[WORD_W-1:0], r_acc[WORD_W-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc <= '0;
      r_opb <= '0;
      r_cnt <= '0;
`ifdef ALU_MDU_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else if (i_start) begin
      r_acc <= {{WORD_W{1'b0}}, i_opa};
      r_opb <= i_opb;
      r_cnt <= CW'(WORD_W - 1);
`ifdef ALU_MDU_DIV_EN
      r_is_div <= i_is_div;
`endif
    end else if (i_run) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);
  assign o_hi   = r_acc[2*WORD_W-1:WORD_W];
  assign o_lo   = r_acc[WORD_W-1:0];

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative multiply/divide behind a valid/ready pair.
// Build option ALU_MDU_DIV_EN adds the divider; without it DIV/DIVU return the poison value.
module alu_mdu
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  aluop_t            ALUOP,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] O,
  output logic [WORD_W-1:0] HI,
  output logic              N,
  output logic              Z,
  output logic              V,
  output logic              DZ,
  output mdu_state_t        o_dbg_state
);

  // Handshakes: a request transfers on an edge where req_valid && req_ready;
  // a response transfers on an edge where resp_valid && resp_ready, and the
  // result stays stable until then.

  localparam int SH  = $clog2(WORD_W);
  localparam int MSB = WORD_W - 1;
  localparam logic [WORD_W-1:0] W_BAD = WORD_W'(ALU_BAD_RESULT);

  mdu_state_t        r_state, w_state_next;
  logic [WORD_W-1:0] r_o, r_hi;
  logic              r_n, r_z, r_v, r_dz, r_neg_lo;
  logic              w_accept, w_is_mdu, w_signed, w_is_div, w_last;
  logic [WORD_W-1:0] w_sum, w_dif, w_simple_o, w_mag_a, w_mag_b, w_it_hi, w_it_lo;
  logic              w_simple_v;
  logic [SH-1:0]     w_shamt;
  logic [2*WORD_W-1:0] w_prod;
  logic [WORD_W-1:0] w_fix_o, w_fix_hi, w_load_o, w_load_hi;
  logic              w_fix_dz, w_load, w_load_v, w_load_dz;

`ifdef ALU_MDU_DIV_EN
  logic              r_is_div, r_neg_hi, r_dz_pend;
  logic [WORD_W-1:0] r_a;
  assign w_is_div = (ALUOP == ALU_DIV) || (ALUOP == ALU_DIVU);
`else
  assign w_is_div = 1'b0;
`endif

  assign req_ready = (r_state == IDLE) && !RST;
  assign w_accept  = req_valid && req_ready;
  assign w_is_mdu  = (ALUOP == ALU_MULT) || (ALUOP == ALU_MULTU) || w_is_div;
  assign w_signed  = (ALUOP == ALU_MULT) || (ALUOP == ALU_DIV);
  assign w_mag_a   = (w_signed && A[MSB]) ? -A : A;
  assign w_mag_b   = (w_signed && B[MSB]) ? -B : B;
  assign w_shamt   = B[SH-1:0];

  always_comb begin
    w_sum      = A + B;
    w_dif      = A - B;
    w_simple_o = W_BAD;
    w_simple_v = 1'b0;
    case (ALUOP)
      ALU_SLL:  w_simple_o = A << w_shamt;
      ALU_SRL:  w_simple_o = A >> w_shamt;
      ALU_ADD: begin
        w_simple_o = w_sum;
        w_simple_v = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
      end
      ALU_SUB: begin
        w_simple_o = w_dif;
        w_simple_v = (A[MSB] != B[MSB]) && (w_dif[MSB] == B[MSB]);
      end
      ALU_AND:  w_simple_o = A & B;
      ALU_OR:   w_simple_o = A | B;
      ALU_XOR:  w_simple_o = A ^ B;
      ALU_NOR:  w_simple_o = ~(A | B);
      ALU_SLT:  w_simple_o = {{(WORD_W-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: w_simple_o = {{(WORD_W-1){1'b0}}, (A < B)};
      default:  w_simple_o = W_BAD;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_is_mdu ? ITER : DONE;
      ITER:    if (w_last) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  mdu_iter #(.WORD_W(WORD_W)) u_iter (
    .CLK      (CLK),
    .RST      (RST),
    .i_start  (w_accept && w_is_mdu),
    .i_run    (r_state == ITER),
    .i_is_div (w_is_div),
    .i_opa    (w_mag_a),
    .i_opb    (w_mag_b),
    .o_last   (w_last),
    .o_hi     (w_it_hi),
    .o_lo     (w_it_lo)
  );

  // Sign correction on the magnitude result; divide-by-zero overrides it.
  always_comb begin
    w_prod   = r_neg_lo ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};
    w_fix_o  = w_prod[WORD_W-1:0];
    w_fix_hi = w_prod[2*WORD_W-1:WORD_W];
    w_fix_dz = 1'b0;
`ifdef ALU_MDU_DIV_EN
    if (r_is_div) begin
      w_fix_o  = r_neg_lo ? -w_it_lo : w_it_lo;
      w_fix_hi = r_neg_hi ? -w_it_hi : w_it_hi;
      if (r_dz_pend) begin
        w_fix_o  = '1;
        w_fix_hi = r_a;
        w_fix_dz = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    w_load    = 1'b0;
    w_load_o  = w_simple_o;
    w_load_hi = '0;
    w_load_v  = w_simple_v;
    w_load_dz = 1'b0;
    if (w_accept && !w_is_mdu) begin
      w_load = 1'b1;
    end else if (r_state == FIX) begin
      w_load    = 1'b1;
      w_load_o  = w_fix_o;
      w_load_hi = w_fix_hi;
      w_load_v  = 1'b0;
      w_load_dz = w_fix_dz;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_o      <= '0;
      r_hi     <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_lo <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_dz_pend <= 1'b0;
      r_a       <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_neg_lo <= w_signed && (A[MSB] ^ B[MSB]);
`ifdef ALU_MDU_DIV_EN
        r_is_div  <= w_is_div;
        r_neg_hi  <= (ALUOP == ALU_DIV) && A[MSB];
        r_dz_pend <= w_is_div && (B == '0);
        r_a       <= A;
`endif
      end
      if (w_load) begin
        r_o  <= w_load_o;
        r_hi <= w_load_hi;
        r_n  <= w_load_o[MSB];
        r_z  <= ~|w_load_o;
        r_v  <= w_load_v;
        r_dz <= w_load_dz;
      end
    end
  end

  assign resp_valid  = (r_state == DONE);
  assign O           = r_o;
  assign HI          = r_hi;
  assign N           = r_n;
  assign Z           = r_z;
  assign V           = r_v;
  assign DZ          = r_dz;
  assign o_dbg_state = r_state;

endmodule
